// File: rtl/vga_pkg.sv
// Default 640x480 @ 72 Hz display timing and the shared coordinate type.
package vga_pkg;

  typedef logic [11:0] coord_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 24;
  localparam int unsigned DEF_H_SYNC    = 40;
  localparam int unsigned DEF_H_BP      = 128;
  localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 9;
  localparam int unsigned DEF_V_SYNC    = 3;
  localparam int unsigned DEF_V_BP      = 28;
  localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic DEF_H_SYNC_POL = 1'b0;
  localparam logic DEF_V_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter with visible and sync-window decode.
// Latency: count updates on the clock after inc; decodes are combinational. No backpressure.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned FP      = DEF_H_FP,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BP      = DEF_H_BP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  output coord_t count,
  output logic   wrap,
  output logic   visible,
  output logic   sync_window
);

  localparam coord_t TOTAL_M1   = coord_t'(VISIBLE + FP + SYNC + BP - 1);
  localparam coord_t SYNC_START = coord_t'(VISIBLE + FP);
  localparam coord_t SYNC_END   = coord_t'(VISIBLE + FP + SYNC - 1);
  localparam coord_t VIS_END    = coord_t'(VISIBLE);

  // Wrap by compare so the counter never reaches TOTAL.
  assign wrap = inc && (count == TOTAL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (inc) begin
      count <= count + coord_t'(1);
    end
  end

  assign visible     = (count < VIS_END);
  assign sync_window = (count >= SYNC_START) && (count <= SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing: pixel coordinates, syncs, video_on and a frame tick.
// Latency: all outputs registered one clock behind the counters. No backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic        H_SYNC_POL = DEF_H_SYNC_POL,
  parameter logic        V_SYNC_POL = DEF_V_SYNC_POL
) (
  input  logic   clk,
  input  logic   rst_n,
  output coord_t pixel_column,
  output coord_t pixel_row,
  output logic   video_on,
  output logic   hsync,
  output logic   vsync,
  output logic   frame_tick
);

  localparam coord_t TICK_ROW = coord_t'(V_VISIBLE);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   h_visible;
  logic   h_sync_win;
  logic   v_wrap_unused;
  logic   v_visible;
  logic   v_sync_win;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (1'b1),
    .count       (h_cnt),
    .wrap        (h_wrap),
    .visible     (h_visible),
    .sync_window (h_sync_win)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (h_wrap),
    .count       (v_cnt),
    .wrap        (v_wrap_unused),
    .visible     (v_visible),
    .sync_window (v_sync_win)
  );

  // Syncs idle at the inverse of their asserted level, including in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_column <= '0;
      pixel_row    <= '0;
      video_on     <= 1'b0;
      hsync        <= ~H_SYNC_POL;
      vsync        <= ~V_SYNC_POL;
      frame_tick   <= 1'b0;
    end else begin
      pixel_column <= h_cnt;
      pixel_row    <= v_cnt;
      video_on     <= h_visible && v_visible;
      hsync        <= h_sync_win ^ ~H_SYNC_POL;
      vsync        <= v_sync_win ^ ~V_SYNC_POL;
      frame_tick   <= (h_cnt == '0) && (v_cnt == TICK_ROW);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small-timing and inverted-polarity instances
// checked against constant vectors and an arithmetic position model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coord_t d_col, d_row, s_col, s_row, p_col, p_row;
  logic   d_von, d_hs, d_vs, d_ft;
  logic   s_von, s_hs, s_vs, s_ft;
  logic   p_von, p_hs, p_vs, p_ft;

  vga_timing_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .pixel_column(d_col), .pixel_row(d_row),
    .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_tick(d_ft)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pixel_column(s_col), .pixel_row(s_row),
    .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_tick(s_ft)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .pixel_column(p_col), .pixel_row(p_row),
    .video_on(p_von), .hsync(p_hs), .vsync(p_vs), .frame_tick(p_ft)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;          // rising edges seen since reset was released
  bit run_chk = 1'b0;
  int last_ft = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  typedef struct packed {
    int col; int row; bit von; bit hs; bit vs; bit ft;
  } exp_t;

  // Expected outputs after kk edges: edge n shows raster position n-1.
  function automatic exp_t model(int kk, int hv, int hf, int hsn, int hb,
                                 int vv, int vf, int vsn, int vb, bit hpol, bit vpol);
    exp_t e;
    int ht, vt, p;
    ht = hv + hf + hsn + hb;
    vt = vv + vf + vsn + vb;
    e = '0;
    e.hs = ~hpol;
    e.vs = ~vpol;
    if (kk > 0) begin
      p = (kk - 1) % (ht * vt);
      e.col = p % ht;
      e.row = p / ht;
      e.von = (e.col < hv) && (e.row < vv);
      e.hs  = (e.col >= hv + hf && e.col < hv + hf + hsn) ? hpol : ~hpol;
      e.vs  = (e.row >= vv + vf && e.row < vv + vf + vsn) ? vpol : ~vpol;
      e.ft  = (e.col == 0) && (e.row == vv);
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  task automatic chk_out(string tag, coord_t col, coord_t row, logic von,
                         logic hs, logic vs, logic ft, exp_t e);
    chk({tag, ".col"}, 32'(col), e.col);
    chk({tag, ".row"}, 32'(row), e.row);
    chk({tag, ".video_on"}, 32'(von), 32'(e.von));
    chk({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    chk({tag, ".frame_tick"}, 32'(ft), 32'(e.ft));
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk_out("dflt", d_col, d_row, d_von, d_hs, d_vs, d_ft,
              model(k, 640, 24, 40, 128, 480, 9, 3, 28, 1'b0, 1'b0));
      chk_out("small", s_col, s_row, s_von, s_hs, s_vs, s_ft,
              model(k, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0));
      chk_out("pol", p_col, p_row, p_von, p_hs, p_vs, p_ft,
              model(k, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1));
      if (k == 0) last_ft = -1;
      if (s_ft) begin
        if (last_ft >= 0) chk("small.tick_period", 32'(k - last_ft), 84);
        last_ft = k;
      end
    end
  end

  typedef struct {
    int k; int col; int row; bit von; bit hs; bit vs; bit ft;
  } vec_t;

  vec_t vecs[$];

  task automatic async_reset_check(string tag);
    // Assert between edges and look before any clock edge can clear outputs.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, ".col"}, 32'(d_col), 0);
    chk({tag, ".row"}, 32'(d_row), 0);
    chk({tag, ".video_on"}, 32'(d_von), 0);
    chk({tag, ".hsync"}, 32'(d_hs), 1);
    chk({tag, ".vsync"}, 32'(d_vs), 1);
    chk({tag, ".pol_hsync"}, 32'(p_hs), 0);
    chk({tag, ".pol_vsync"}, 32'(p_vs), 0);
    chk({tag, ".small_col"}, 32'(s_col), 0);
  endtask

  initial begin
    vecs.push_back('{1,    0,   0, 1, 1, 1, 0});
    vecs.push_back('{2,    1,   0, 1, 1, 1, 0});
    vecs.push_back('{640,  639, 0, 1, 1, 1, 0});
    vecs.push_back('{641,  640, 0, 0, 1, 1, 0});
    vecs.push_back('{664,  663, 0, 0, 1, 1, 0});
    vecs.push_back('{665,  664, 0, 0, 0, 1, 0});
    vecs.push_back('{704,  703, 0, 0, 0, 1, 0});
    vecs.push_back('{705,  704, 0, 0, 1, 1, 0});
    vecs.push_back('{832,  831, 0, 0, 1, 1, 0});
    vecs.push_back('{833,  0,   1, 1, 1, 1, 0});
    vecs.push_back('{1473, 640, 1, 0, 1, 1, 0});
    vecs.push_back('{1497, 664, 1, 0, 0, 1, 0});
    vecs.push_back('{1665, 0,   2, 1, 1, 1, 0});

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst.hsync", 32'(d_hs), 1);
    chk("rst.vsync", 32'(d_vs), 1);
    chk("rst.video_on", 32'(d_von), 0);
    chk("rst.col", 32'(d_col), 0);
    chk("rst.pol_hsync", 32'(p_hs), 0);
    chk("rst.pol_vsync", 32'(p_vs), 0);
    run_chk = 1'b1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int g = 0; g < 4000 && k < vecs[i].k; g++) @(negedge clk);
      chk("vec.k_reached", 32'(k), 32'(vecs[i].k));
      chk("vec.col", 32'(d_col), 32'(vecs[i].col));
      chk("vec.row", 32'(d_row), 32'(vecs[i].row));
      chk("vec.video_on", 32'(d_von), 32'(vecs[i].von));
      chk("vec.hsync", 32'(d_hs), 32'(vecs[i].hs));
      chk("vec.vsync", 32'(d_vs), 32'(vecs[i].vs));
      chk("vec.frame_tick", 32'(d_ft), 32'(vecs[i].ft));
    end

    // Mid-line, mid-frame async reset, then restart from (0,0).
    async_reset_check("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart.col", 32'(d_col), 0);
    chk("restart.row", 32'(d_row), 0);
    chk("restart.video_on", 32'(d_von), 1);

    // Several uninterrupted small frames to exercise the simultaneous wrap.
    repeat (3 * 84 + 5) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(10, 250)) @(negedge clk);
      #($urandom_range(1, 4)) rst_n = 1'b0;
      #1 chk("rnd_rst.small_row", 32'(s_row), 0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (3 * 84 + 5) @(negedge clk);

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
